// File: rtl/eth_mac_pkg.sv
// eth_mac_pkg: shared constants, input FSM states and width helpers for the MAC packet FIFO
package eth_mac_pkg;
  localparam int MODE_CUT_THROUGH = 0;
  localparam int MODE_STORE_FWD = 1;
  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DISCARD} in_state_e;
  function automatic int bsel_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction
endpackage

// File: rtl/eth_sdp_ram.sv
// eth_sdp_ram: simple dual-port RAM, one write port and one registered read port held when idle
module eth_sdp_ram #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/eth_pkt_fifo_v4.sv
// eth_pkt_fifo_v4: word packet FIFO with cut-through or store-and-forward frame handling
module eth_pkt_fifo_v4 import eth_mac_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 512,
  parameter int MODE = MODE_STORE_FWD,
  parameter int CNT_W = 16,
  parameter int BSEL_W = bsel_w(DATA_W),
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk_app_i,
  input  logic              rst_clk_app_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_start_i,
  input  logic              in_end_i,
  input  logic [BSEL_W-1:0] in_bytesel_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_start_o,
  output logic              out_end_o,
  output logic [BSEL_W-1:0] out_bytesel_o,
  input  logic              out_ready_i,
  output logic [AW:0]       level_o,
  output logic [AW:0]       frame_cnt_o,
  output logic              drop_pulse_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);
  localparam int RW = DATA_W + BSEL_W + 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam bit SF = (MODE == MODE_STORE_FWD);
  in_state_e st, st_nxt;
  logic [AW:0] wr_ptr, commit_ptr, rd_ptr, fetch_ptr, wr_nxt, wa, fcnt;
  logic up, acc, room, we, commit, drop, re, ov, pop, after_end;
  logic [RW-1:0] rdata;
  assign acc = in_valid_i && in_ready_o;
  // a start word always lands at commit_ptr, which also rewinds an aborted frame
  assign wa = (SF && in_start_i) ? commit_ptr : wr_ptr;
  assign room = wa - rd_ptr != FULL;
  assign in_ready_o = up && (SF || wr_ptr - rd_ptr != FULL);
  assign pop = ov && out_ready_i;
  assign re = (SF ? commit_ptr : wr_ptr) != fetch_ptr && (!ov || out_ready_i) && !flush_i;
  always_comb begin
    st_nxt = st;
    we = 1'b0;
    wr_nxt = wr_ptr;
    commit = 1'b0;
    drop = 1'b0;
    if (acc && !SF) begin
      we = 1'b1;
      wr_nxt = wr_ptr + 1'b1;
    end else if (acc && (in_start_i || st == S_FRAME)) begin
      drop = (in_start_i && st == S_FRAME) || !room;
      we = room;
      wr_nxt = room ? wa + 1'b1 : commit_ptr;
      commit = room && in_end_i;
      st_nxt = in_end_i ? S_IDLE : room ? S_FRAME : S_DISCARD;
    end else if (acc) begin
      drop = st == S_IDLE;
      st_nxt = in_end_i ? S_IDLE : st;
    end
  end
  always_ff @(posedge clk_app_i) begin
    if (rst_clk_app_i || flush_i) begin
      st <= S_IDLE;
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
      fetch_ptr <= '0;
      ov <= 1'b0;
      after_end <= 1'b1;
      fcnt <= '0;
    end else begin
      st <= st_nxt;
      wr_ptr <= wr_nxt;
      if (commit) commit_ptr <= wa + 1'b1;
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      fetch_ptr <= fetch_ptr + (AW+1)'(re);
      ov <= re || (ov && !out_ready_i);
      if (pop) after_end <= out_end_o;
      fcnt <= fcnt + (AW+1)'(commit) - (AW+1)'(SF && pop && out_end_o);
    end
  end
  always_ff @(posedge clk_app_i) begin
    up <= !rst_clk_app_i;
    drop_pulse_o <= !rst_clk_app_i && !flush_i && drop;
    if (rst_clk_app_i) drop_cnt_o <= '0;
    else if (drop && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + 1'b1;
  end
  eth_sdp_ram #(.W(RW), .DEPTH(DEPTH)) u_ram (
    .clk(clk_app_i),
    .we(we),
    .waddr(wa[AW-1:0]),
    .wdata({in_end_i, in_bytesel_i, in_data_i}),
    .re(re),
    .raddr(fetch_ptr[AW-1:0]),
    .rdata(rdata)
  );
  assign out_valid_o = ov;
  assign {out_end_o, out_bytesel_o, out_data_o} = ov ? rdata : '0;
  assign out_start_o = ov && after_end;
  assign level_o = wr_ptr - rd_ptr;
  assign frame_cnt_o = SF ? fcnt : '0;
endmodule

// File: tb/tb_eth_pkt_fifo_v4.sv
// tb_eth_pkt_fifo_v4: store-and-forward and cut-through instances checked against frame-level models
module tb_eth_pkt_fifo_v4;
  localparam int DW = 32, BW = 2, AW = 4, DEP = 16;
  logic clk = 0, rst = 1, s_flush = 0;
  always #5 clk = ~clk;
  logic s_iv = 0, s_is = 0, s_ie = 0, s_ir, s_ov, s_os, s_oe, s_ordy, s_dp, s_rdy_en = 1, s_rbit = 1, s_rnd = 0;
  logic [DW-1:0] s_id = 0, s_od;
  logic [BW-1:0] s_ib = 0, s_ob;
  logic [AW:0] s_lvl, s_fc;
  logic [7:0] s_dc;
  logic c_iv = 0, c_is = 0, c_ie = 0, c_ir, c_ov, c_os, c_oe, c_ordy, c_dp, c_rdy_en = 1, c_rbit = 1, c_rnd = 0;
  logic [DW-1:0] c_id = 0, c_od;
  logic [BW-1:0] c_ib = 0, c_ob;
  logic [AW:0] c_lvl, c_fc;
  logic [15:0] c_dc;
  assign s_ordy = s_rdy_en && s_rbit;
  assign c_ordy = c_rdy_en && c_rbit;
  eth_pkt_fifo_v4 #(.DATA_W(DW), .DEPTH(DEP), .MODE(1), .CNT_W(8)) u_sf (
    .clk_app_i(clk), .rst_clk_app_i(rst), .flush_i(s_flush),
    .in_valid_i(s_iv), .in_data_i(s_id), .in_start_i(s_is), .in_end_i(s_ie), .in_bytesel_i(s_ib),
    .in_ready_o(s_ir), .out_valid_o(s_ov), .out_data_o(s_od), .out_start_o(s_os), .out_end_o(s_oe),
    .out_bytesel_o(s_ob), .out_ready_i(s_ordy), .level_o(s_lvl), .frame_cnt_o(s_fc),
    .drop_pulse_o(s_dp), .drop_cnt_o(s_dc));
  eth_pkt_fifo_v4 #(.DATA_W(DW), .DEPTH(DEP), .MODE(0), .CNT_W(16)) u_ct (
    .clk_app_i(clk), .rst_clk_app_i(rst), .flush_i(1'b0),
    .in_valid_i(c_iv), .in_data_i(c_id), .in_start_i(c_is), .in_end_i(c_ie), .in_bytesel_i(c_ib),
    .in_ready_o(c_ir), .out_valid_o(c_ov), .out_data_o(c_od), .out_start_o(c_os), .out_end_o(c_oe),
    .out_bytesel_o(c_ob), .out_ready_i(c_ordy), .level_o(c_lvl), .frame_cnt_o(c_fc),
    .drop_pulse_o(c_dp), .drop_cnt_o(c_dc));
  int n_chk = 0, n_fail = 0, s_drops = 0, c_seen = 0;
  bit s_in_frame = 0, s_disc = 0, c_last_end = 1;
  logic [DW+BW+1:0] s_exp[$], s_cur[$], c_exp[$];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int sat(input int v);
    return v > 255 ? 255 : v;
  endfunction
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(posedge clk) begin
    #1;
    s_rbit = s_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    c_rbit = c_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  end
  always @(negedge clk) begin
    if (!rst && s_ov && s_ordy) begin
      if (s_exp.size() == 0) check("s_extra_word", s_exp.size(), 1);
      else check("s_word", {s_os, s_oe, s_oe ? s_ob : 2'b0, s_od}, s_exp.pop_front());
    end
    if (!rst && c_ov && c_ordy) begin
      c_seen++;
      if (c_exp.size() == 0) check("c_extra_word", c_exp.size(), 1);
      else check("c_word", {c_os, c_oe, c_oe ? c_ob : 2'b0, c_od}, c_exp.pop_front());
    end
  end
  // frame-level view of store-and-forward: only whole, unaborted frames that fit survive
  task automatic s_tx(input logic st, input logic en, input logic [BW-1:0] b, input logic [DW-1:0] d);
    logic [DW+BW+1:0] w;
    int t;
    w = {st, en, en ? b : 2'b0, d};
    if (st) begin
      if (s_in_frame) s_drops++;
      s_cur.delete();
      s_cur.push_back(w);
      s_in_frame = 1;
      s_disc = 0;
    end else if (s_in_frame && s_cur.size() == DEP) begin
      s_drops++;
      s_cur.delete();
      s_in_frame = 0;
      s_disc = !en;
    end else if (s_in_frame) s_cur.push_back(w);
    else if (s_disc) s_disc = !en;
    else s_drops++;
    if (s_in_frame && en) begin
      foreach (s_cur[i]) s_exp.push_back(s_cur[i]);
      s_cur.delete();
      s_in_frame = 0;
    end
    s_iv = 1; s_is = st; s_ie = en; s_ib = b; s_id = d;
    @(negedge clk);
    for (t = 0; t < 200 && !s_ir; t++) @(negedge clk);
    if (!s_ir) check("s_in_ready_timeout", s_ir, 1);
    @(posedge clk);
    #1;
    s_iv = 0;
  endtask
  task automatic c_tx(input logic st, input logic en, input logic [BW-1:0] b, input logic [DW-1:0] d);
    int t;
    c_exp.push_back({c_last_end, en, en ? b : 2'b0, d});
    c_last_end = en;
    c_iv = 1; c_is = st; c_ie = en; c_ib = b; c_id = d;
    @(negedge clk);
    for (t = 0; t < 200 && !c_ir; t++) @(negedge clk);
    if (!c_ir) check("c_in_ready_timeout", c_ir, 1);
    @(posedge clk);
    #1;
    c_iv = 0;
  endtask
  initial begin
    int kind, len, p, base;
    tick(3);
    check("rst_s_ready", s_ir, 0);
    check("rst_c_ready", c_ir, 0);
    check("rst_s_valid", s_ov, 0);
    check("rst_s_level", s_lvl, 0);
    check("rst_s_dropcnt", s_dc, 0);
    rst = 0;
    tick(1);
    check("post_rst_s_ready", s_ir, 1);
    check("post_rst_c_ready", c_ir, 1);
    for (int i = 0; i < 5; i++) s_tx(i == 0, i == 4, 2, 32'hA000_0000 + i);
    check("sf_fc_commit", s_fc, 1);
    check("sf_valid_n1", s_ov, 0);
    tick(1);
    check("sf_valid_n2", s_ov, 1);
    check("sf_start_n2", s_os, 1);
    tick(8);
    check("sf_fc_drained", s_fc, 0);
    check("sf_5w_drained", s_exp.size(), 0);
    for (int i = 0; i < 3; i++) s_tx(i == 0, 0, 0, 32'hB000_0000 + i);
    s_tx(1, 0, 0, 32'hB100_0000);
    s_tx(0, 1, 3, 32'hB100_0001);
    tick(1);
    check("abort_dropcnt", s_dc, sat(s_drops));
    tick(6);
    check("abort_drained", s_exp.size(), 0);
    for (int i = 0; i < 20; i++) s_tx(i == 0, i == 19, 1, 32'hC000_0000 + i);
    check("oversize_level", s_lvl, 0);
    check("oversize_dropcnt", s_dc, sat(s_drops));
    for (int i = 0; i < 4; i++) s_tx(i == 0, i == 3, 0, 32'hC100_0000 + i);
    tick(8);
    check("oversize_next_drained", s_exp.size(), 0);
    s_tx(0, 0, 0, 32'hD000_0000);
    check("orphan_pulse", s_dp, 1);
    tick(1);
    check("orphan_pulse_end", s_dp, 0);
    check("orphan_dropcnt", s_dc, sat(s_drops));
    s_rdy_en = 0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 3; i++) s_tx(i == 0, i == 2, 0, 32'hE000_0000 + f * 16 + i);
    s_tx(1, 0, 0, 32'hE100_0000);
    s_tx(0, 0, 0, 32'hE100_0001);
    check("flush_pre_fc", s_fc, 3);
    check("flush_pre_valid", s_ov, 1);
    s_flush = 1;
    tick(1);
    s_flush = 0;
    s_exp.delete(); s_cur.delete(); s_in_frame = 0; s_disc = 0;
    check("flush_level", s_lvl, 0);
    check("flush_fc", s_fc, 0);
    check("flush_valid", s_ov, 0);
    check("flush_dropcnt", s_dc, sat(s_drops));
    s_rdy_en = 1;
    s_rnd = 1;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 4);
      len = $urandom_range(1, 6);
      p = (kind == 4) ? $urandom_range(1, 3) : 0;
      for (int t = 0; t < 2000 && s_exp.size() + len + p > DEP; t++) tick(1);
      if (kind == 3) s_tx(0, 1'($urandom_range(0, 1)), 0, $urandom);
      else begin
        for (int i = 0; i < p; i++) s_tx(i == 0, 0, 2'($urandom_range(0, 3)), $urandom);
        for (int i = 0; i < len; i++) s_tx(i == 0, i == len - 1, 2'($urandom_range(0, 3)), $urandom);
      end
      tick($urandom_range(0, 2));
    end
    s_rnd = 0;
    for (int t = 0; t < 300 && s_exp.size() != 0; t++) tick(1);
    tick(2);
    check("s_rand_drained", s_exp.size(), 0);
    check("s_rand_level", s_lvl, 0);
    check("s_rand_fc", s_fc, 0);
    check("s_rand_dropcnt", s_dc, sat(s_drops));
    for (int i = 0; i < 260; i++) s_tx(0, 0, 0, i);
    tick(1);
    check("dropcnt_saturate", s_dc, sat(s_drops));
    c_tx(1, 1, 1, 32'h1234_5678);
    check("ct_valid_n1", c_ov, 0);
    tick(1);
    check("ct_valid_n2", c_ov, 1);
    tick(3);
    c_rdy_en = 0;
    for (int i = 0; i < 16; i++) c_tx(i % 4 == 0, i % 4 == 3, 2'(i), 32'hF000_0000 + i);
    check("ct_full_ready", c_ir, 0);
    check("ct_full_level", c_lvl, 16);
    c_rdy_en = 1;
    base = c_seen;
    repeat (16) @(negedge clk);
    #1;
    check("ct_drain_rate", c_seen - base, 16);
    tick(2);
    check("ct_drained", c_exp.size(), 0);
    c_rnd = 1;
    for (int i = 0; i < 150; i++) begin
      c_tx(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
      tick($urandom_range(0, 1));
    end
    c_rnd = 0;
    for (int t = 0; t < 300 && c_exp.size() != 0; t++) tick(1);
    check("c_rand_drained", c_exp.size(), 0);
    check("c_level", c_lvl, 0);
    check("c_fc_zero", c_fc, 0);
    check("c_dropcnt_zero", c_dc, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
